// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI pixel buffer.
package spi_pkg;

  // Image buffer occupancy.
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } buf_state_e;

  localparam int unsigned NUM_PIXEL_BYTES = 72;
  localparam int unsigned LABEL_W         = 10;
  localparam logic [3:0]  LABEL_INVALID   = 4'hF;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary encoder; flags inputs that are not exactly one-hot.
module onehot_encoder #(
  parameter int unsigned LABEL_W = spi_pkg::LABEL_W
) (
  input  logic [LABEL_W-1:0] onehot,
  output logic [3:0]         idx,
  output logic               valid
);
  import spi_pkg::*;

  logic [4:0] ones;
  logic [3:0] pos;

  // Count set bits and remember the position of the last one seen.
  always_comb begin
    ones = '0;
    pos  = '0;
    for (int i = 0; i < int'(LABEL_W); i++) begin
      if (onehot[i]) begin
        ones = ones + 5'd1;
        pos  = 4'(i);
      end
    end
    valid = (ones == 5'd1);
    idx   = valid ? pos : LABEL_INVALID;
  end

endmodule

// File: rtl/spi_pixel_buffer.sv
// Frame buffer for SPI pixel bytes plus expected-label latch for the cost unit.
module spi_pixel_buffer #(
  parameter int unsigned NUM_BYTES = spi_pkg::NUM_PIXEL_BYTES,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned LABEL_W   = spi_pkg::LABEL_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               shift_SPI,
  input  logic [DATA_W-1:0]  SPI_in,
  input  logic               write_en,
  input  logic               calculate_cost,
  input  logic [LABEL_W-1:0] expected_label,
  input  logic               image_consumed,
  input  logic               cost_ack,
  input  logic               clear_err,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               image_ready,
  output logic [ADDR_W-1:0]  byte_count,
  output logic               label_valid,
  output logic [3:0]         label_idx,
  output logic               overflow_err,
  output logic               frame_err,
  output logic               label_err
);
  import spi_pkg::*;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_BYTES - 1);

  buf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic              label_valid_q, label_valid_d;
  logic [3:0]        label_idx_q, label_idx_d;
  logic              label_err_q, label_err_d;
  logic              wr;
  logic              mem_we;
  logic [3:0]        enc_idx;
  logic              enc_valid;

  logic [DATA_W-1:0] mem [NUM_BYTES];

  assign wr     = shift_SPI & write_en;
  // The pointer equals the next free slot in IDLE/FILL; FULL freezes the buffer.
  assign mem_we = wr & (state_q != FULL);

  onehot_encoder #(
    .LABEL_W (LABEL_W)
  ) u_encoder (
    .onehot (expected_label),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  // Buffer storage: no reset, contents survive frame errors and resets.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q] <= SPI_in;
    end
  end

  // Read-before-write: same-cycle write is not forwarded. Out-of-range reads give 0.
  assign rd_data = ({1'b0, rd_addr} < (ADDR_W + 1)'(NUM_BYTES)) ? mem[rd_addr] : '0;

  // Frame FSM next state, pointer and frame error pulse.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr) begin
          count_d = ADDR_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (wr) begin
          count_d = count_q + ADDR_W'(1);
          if (count_q == LastIdx) begin
            state_d = FULL;
          end
        end else if (!write_en) begin
          frame_err_d = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      FULL: begin
        if (image_consumed) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Label latch and sticky error flags; a new error beats a simultaneous clear.
  always_comb begin
    label_valid_d = label_valid_q;
    label_idx_d   = label_idx_q;
    if (calculate_cost) begin
      label_valid_d = 1'b1;
      label_idx_d   = enc_idx;
    end else if (cost_ack) begin
      label_valid_d = 1'b0;
    end
    overflow_d  = (wr & (state_q == FULL)) | (overflow_q & ~clear_err);
    label_err_d = (calculate_cost & ~enc_valid) | (label_err_q & ~clear_err);
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      label_valid_q <= 1'b0;
      label_idx_q   <= '0;
      label_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
      label_valid_q <= label_valid_d;
      label_idx_q   <= label_idx_d;
      label_err_q   <= label_err_d;
    end
  end

  assign image_ready  = (state_q == FULL);
  assign byte_count   = count_q;
  assign frame_err    = frame_err_q;
  assign overflow_err = overflow_q;
  assign label_valid  = label_valid_q;
  assign label_idx    = label_idx_q;
  assign label_err    = label_err_q;

endmodule

// File: tb/tb_spi_pixel_buffer.sv
// Self-checking bench: directed scenarios with literal checks plus random traffic
// compared every cycle against a frame-level behavioural model.
module tb_spi_pixel_buffer;

  localparam int NB = 72;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       shift_SPI;
  logic [7:0] SPI_in;
  logic       write_en;
  logic       calculate_cost;
  logic [9:0] expected_label;
  logic       image_consumed;
  logic       cost_ack;
  logic       clear_err;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       image_ready;
  logic [6:0] byte_count;
  logic       label_valid;
  logic [3:0] label_idx;
  logic       overflow_err;
  logic       frame_err;
  logic       label_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: frame length so far, known buffer contents, flags.
  int       m_len;
  bit [7:0] m_mem   [NB];
  bit       m_known [NB];
  bit       m_fe, m_ovf, m_lerr, m_lvalid;
  int       m_lidx;

  always #5 clk = ~clk;

  spi_pixel_buffer dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .shift_SPI      (shift_SPI),
    .SPI_in         (SPI_in),
    .write_en       (write_en),
    .calculate_cost (calculate_cost),
    .expected_label (expected_label),
    .image_consumed (image_consumed),
    .cost_ack       (cost_ack),
    .clear_err      (clear_err),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .image_ready    (image_ready),
    .byte_count     (byte_count),
    .label_valid    (label_valid),
    .label_idx      (label_idx),
    .overflow_err   (overflow_err),
    .frame_err      (frame_err),
    .label_err      (label_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int label_index(input logic [9:0] l);
    int ones = 0;
    int pos  = 0;
    for (int i = 0; i < 10; i++) begin
      if (l[i]) begin
        ones++;
        pos = i;
      end
    end
    return (ones == 1) ? pos : 15;
  endfunction

  task automatic model_reset();
    m_len = 0; m_fe = 0; m_ovf = 0; m_lerr = 0; m_lvalid = 0; m_lidx = 0;
  endtask

  // Apply one clock edge's worth of the specified behaviour to the model.
  task automatic model_update();
    bit wr;
    bit ovf_ev, lerr_ev;
    if (!n_rst) return;
    wr      = shift_SPI & write_en;
    ovf_ev  = 0;
    lerr_ev = 0;
    m_fe    = 0;
    if (m_len == NB) begin
      if (wr) ovf_ev = 1;
      if (image_consumed) m_len = 0;
    end else if (wr) begin
      m_mem[m_len]   = SPI_in;
      m_known[m_len] = 1;
      m_len++;
    end else if (m_len > 0 && !write_en) begin
      m_fe  = 1;
      m_len = 0;
    end
    if (calculate_cost) begin
      m_lvalid = 1;
      m_lidx   = label_index(expected_label);
      if (m_lidx == 15) lerr_ev = 1;
    end else if (cost_ack) begin
      m_lvalid = 0;
    end
    m_ovf  = ovf_ev  | (m_ovf  & ~clear_err);
    m_lerr = lerr_ev | (m_lerr & ~clear_err);
  endtask

  // Every posedge passes through here so the model never misses an edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Compare process: registered outputs and buffer reads against the model.
  always @(negedge clk) begin
    if (n_rst) begin
      chk("image_ready", int'(image_ready), int'(m_len == NB));
      chk("byte_count", int'(byte_count), m_len);
      chk("frame_err", int'(frame_err), int'(m_fe));
      chk("overflow_err", int'(overflow_err), int'(m_ovf));
      chk("label_err", int'(label_err), int'(m_lerr));
      chk("label_valid", int'(label_valid), int'(m_lvalid));
      chk("label_idx", int'(label_idx), m_lidx);
      if (int'(rd_addr) < NB && m_known[rd_addr])
        chk("rd_data", int'(rd_data), int'(m_mem[rd_addr]));
    end
  end

  task automatic idle_inputs();
    shift_SPI = 0; SPI_in = 0; calculate_cost = 0; expected_label = 0;
    image_consumed = 0; cost_ack = 0; clear_err = 0;
  endtask

  task automatic fill(input int n, input int base);
    write_en = 1;
    for (int i = 0; i < n; i++) begin
      shift_SPI = 1;
      SPI_in    = 8'(base + i);
      tick();
    end
    shift_SPI = 0;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) m_known[i] = 0;
    model_reset();
    n_rst = 0;
    write_en = 0;
    rd_addr = 0;
    idle_inputs();
    #1;
    chk("reset image_ready", int'(image_ready), 0);
    chk("reset byte_count", int'(byte_count), 0);
    chk("reset label_valid", int'(label_valid), 0);
    chk("reset label_idx", int'(label_idx), 0);
    chk("reset overflow_err", int'(overflow_err), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset label_err", int'(label_err), 0);
    tick();
    tick();
    n_rst = 1;
    tick();

    // Full frame of 0..71.
    fill(NB, 0);
    @(negedge clk);
    chk("full image_ready", int'(image_ready), 1);
    chk("full byte_count", int'(byte_count), 72);
    for (int i = 0; i < NB; i++) begin
      rd_addr = 7'(i);
      tick();
      @(negedge clk);
      chk("frame readback", int'(rd_data), i);
    end

    // Overflow while full, buffer frozen.
    for (int i = 0; i < 3; i++) begin
      shift_SPI = 1;
      SPI_in    = 8'hAA;
      tick();
    end
    shift_SPI = 0;
    rd_addr = 7'd5;
    @(negedge clk);
    chk("overflow set", int'(overflow_err), 1);
    chk("frozen rd_data", int'(rd_data), 5);
    clear_err = 1;
    tick();
    clear_err = 0;
    @(negedge clk);
    chk("overflow cleared", int'(overflow_err), 0);
    image_consumed = 1;
    tick();
    image_consumed = 0;
    @(negedge clk);
    chk("consumed image_ready", int'(image_ready), 0);
    chk("consumed byte_count", int'(byte_count), 0);

    // Partial frame then write_en drop.
    fill(30, 200);
    write_en = 0;
    tick();
    @(negedge clk);
    chk("frame_err pulse", int'(frame_err), 1);
    chk("abort byte_count", int'(byte_count), 0);
    chk("abort image_ready", int'(image_ready), 0);
    tick();
    @(negedge clk);
    chk("frame_err one cycle", int'(frame_err), 0);
    fill(NB, 50);
    @(negedge clk);
    chk("refill image_ready", int'(image_ready), 1);
    image_consumed = 1;
    tick();
    image_consumed = 0;

    // Label path.
    expected_label = 10'b0000001000;
    calculate_cost = 1;
    tick();
    calculate_cost = 0;
    @(negedge clk);
    chk("label_idx 3", int'(label_idx), 3);
    chk("label_valid set", int'(label_valid), 1);
    cost_ack = 1;
    tick();
    cost_ack = 0;
    @(negedge clk);
    chk("label_valid ack", int'(label_valid), 0);
    expected_label = 10'b0010000000;
    calculate_cost = 1;
    cost_ack = 1;
    tick();
    calculate_cost = 0;
    cost_ack = 0;
    @(negedge clk);
    chk("label_idx 7", int'(label_idx), 7);
    chk("label_valid cc+ack", int'(label_valid), 1);
    expected_label = 10'b0;
    calculate_cost = 1;
    tick();
    calculate_cost = 0;
    tick();
    @(negedge clk);
    chk("label_idx invalid", int'(label_idx), 15);
    chk("label_err sticky", int'(label_err), 1);
    expected_label = 10'b0000000011;
    calculate_cost = 1;
    clear_err = 1;
    tick();
    calculate_cost = 0;
    clear_err = 0;
    @(negedge clk);
    chk("label_err beats clear", int'(label_err), 1);
    clear_err = 1;
    tick();
    clear_err = 0;
    @(negedge clk);
    chk("label_err cleared", int'(label_err), 0);

    // Reset in the middle of a fill.
    expected_label = 10'b0;
    calculate_cost = 1;
    tick();
    calculate_cost = 0;
    fill(40, 9);
    n_rst = 0;
    model_reset();
    #1;
    chk("midreset byte_count", int'(byte_count), 0);
    chk("midreset label_valid", int'(label_valid), 0);
    chk("midreset label_idx", int'(label_idx), 0);
    chk("midreset label_err", int'(label_err), 0);
    chk("midreset image_ready", int'(image_ready), 0);
    tick();
    tick();
    n_rst = 1;
    tick();
    fill(NB, 100);
    rd_addr = 7'd0;
    @(negedge clk);
    chk("post-reset addr0", int'(rd_data), 100);
    chk("post-reset full", int'(image_ready), 1);
    rd_addr = 7'd40;
    tick();
    @(negedge clk);
    chk("post-reset addr40", int'(rd_data), 140);
    image_consumed = 1;
    tick();
    idle_inputs();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      shift_SPI = ($urandom_range(0, 99) < 60);
      SPI_in    = 8'($urandom);
      if ($urandom_range(0, 99) < 4) write_en = ~write_en;
      else if (!write_en && $urandom_range(0, 99) < 30) write_en = 1;
      image_consumed = ($urandom_range(0, 99) < 10);
      calculate_cost = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 70) expected_label = 10'(1) << $urandom_range(0, 9);
      else expected_label = 10'($urandom);
      cost_ack  = ($urandom_range(0, 99) < 15);
      clear_err = ($urandom_range(0, 99) < 3);
      rd_addr   = 7'($urandom_range(0, NB - 1));
      tick();
    end
    idle_inputs();
    tick();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_pixel_buffer.md
Name: spi_pixel_buffer

Overview:
Downstream consumer of the SPI input controller's byte stream. Captures each strobed pixel byte (shift_SPI qualified by write_en) into a NUM_BYTES x 8 image buffer and signals the classifier when a full frame is resident. Latches the one-hot expected label on calculate_cost, presents it binary-encoded to the cost unit, and reports framing, overflow and label errors.

Parameters:
NUM_BYTES, 72, pixel bytes per frame
DATA_W, 8, byte width
ADDR_W, 7, buffer address width (must satisfy 2^ADDR_W >= NUM_BYTES)
LABEL_W, 10, one-hot label width

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  asynchronous active-low reset
shift_SPI  in  1  one-cycle strobe: SPI_in holds a new byte
SPI_in  in  DATA_W  received byte
write_en  in  1  high while the upstream controller is loading pixels
calculate_cost  in  1  one-cycle pulse: expected_label is valid
expected_label  in  LABEL_W  one-hot expected digit
image_consumed  in  1  classifier has finished with the frame; releases buffer
cost_ack  in  1  cost unit has taken the label
clear_err  in  1  clears sticky error flags
rd_addr  in  ADDR_W  classifier read address
rd_data  out  DATA_W  buffer[rd_addr], combinational read
image_ready  out  1  full frame resident
byte_count  out  ADDR_W  bytes written in the current frame
label_valid  out  1  latched label available
label_idx  out  4  binary index of the latched label
overflow_err  out  1  sticky: write strobe while FULL
frame_err  out  1  one-cycle pulse: write_en dropped mid-frame
label_err  out  1  sticky: latched label not exactly one-hot

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer 0; buffer contents not reset.
- Write qualifier wr = shift_SPI & write_en.
- IDLE: wr -> buffer[0] <= SPI_in, byte_count=1, go FILL. write_en without strobe: stay.
- FILL: wr -> buffer[byte_count] <= SPI_in, byte_count++. Write of byte NUM_BYTES-1 -> FULL; image_ready=1 on the following cycle. byte_count then reads NUM_BYTES.
- FILL, write_en low with no wr -> frame_err pulses 1 cycle, byte_count=0, go IDLE. Partial data is left in the buffer; image_ready stays 0.
- FULL: image_ready=1, buffer frozen. wr -> byte dropped, overflow_err set. image_consumed -> IDLE next cycle, byte_count=0, image_ready=0. image_consumed and wr in the same cycle: the byte is dropped and overflow_err is set.
- image_consumed outside FULL: ignored.
- rd_data: combinational. A read and a write to the same address in one cycle returns the old value.
- Label: calculate_cost -> label_idx <= encode(expected_label), label_valid=1 next cycle. cost_ack clears label_valid. calculate_cost and cost_ack in the same cycle: the new label is captured and label_valid stays 1.
- Label encoding: an input that is zero or has more than one bit set gives label_idx=0xF and sets label_err.
- clear_err clears overflow_err and label_err. A new error event in the same cycle as clear_err wins, so the flag stays 1.
- Label path is independent of the image FSM; both can update in the same cycle.
- Pointer never wraps: writes stop at NUM_BYTES.

Decomposition:
- Package spi_pkg: buffer state enum {IDLE, FILL, FULL}; constants NUM_PIXEL_BYTES=72, LABEL_W=10, LABEL_INVALID=4'hF.
- Sub-module onehot_encoder: LABEL_W one-hot in, 4-bit index plus valid out. Purely combinational; used by the label latch.

Test Plan:
- 72 strobes with write_en=1, SPI_in=i -> image_ready=1 one cycle after the 72nd strobe; rd_addr=0..71 returns 0..71; byte_count=72.
- FULL, then 3 extra strobes -> overflow_err=1, rd_addr=5 still returns 5; clear_err -> overflow_err=0.
- 30 strobes, then write_en=0 -> one-cycle frame_err, byte_count=0, image_ready=0; then a full 72-byte frame -> image_ready=1.
- expected_label=10'b0000001000 with calculate_cost -> label_idx=3, label_valid=1. cost_ack -> label_valid=0. calculate_cost and cost_ack together with label bit 7 -> label_idx=7, label_valid=1.
- expected_label=0 with calculate_cost -> label_idx=0xF, label_err=1 until clear_err.
- Reset asserted mid-FILL (byte 40) -> all outputs 0 immediately; the next frame fills from address 0.
